// File: rtl/pipe8085_pkg.sv
// Shared types for the 8085 EX->WB slice: register indices, PSW bit layout,
// writeback FSM states and the pipeline entry captured from the ALU.
package pipe8085_pkg;

    typedef enum logic [2:0] {
        REG_B = 3'd0,
        REG_C = 3'd1,
        REG_D = 3'd2,
        REG_E = 3'd3,
        REG_H = 3'd4,
        REG_L = 3'd5,
        REG_M = 3'd6,
        REG_A = 3'd7
    } reg_idx_t;

    typedef enum int {
        PSW_CY = 0,
        PSW_P  = 2,
        PSW_AC = 4,
        PSW_Z  = 6,
        PSW_S  = 7
    } psw_bit_t;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        MEM_WAIT
    } wb_state_t;

    typedef struct packed {
        logic [7:0] result;
        logic       z;
        logic       cy;
        logic [2:0] dest;
        logic       wr_reg;
        logic       wr_flags;
    } wb_entry_t;

    // AC is never produced by this ALU, and bits 5/3 read as 0 while bit 1 reads as 1.
    function automatic logic [7:0] make_psw(input logic [7:0] res, input logic z, input logic cy);
        logic [7:0] p;
        p         = 8'h02;
        p[PSW_S]  = res[7];
        p[PSW_Z]  = z;
        p[PSW_AC] = 1'b0;
        p[PSW_P]  = ~^res;
        p[PSW_CY] = cy;
        return p;
    endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// EX-side handshake plus memory write port of the writeback stage.
// master = upstream/memory environment, slave = the writeback stage.
interface alu_writeback_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [7:0]  ex_result;
    logic        ex_z;
    logic        ex_cy;
    logic [2:0]  ex_dest;
    logic        ex_wr_reg;
    logic        ex_wr_flags;
    logic        mem_wr_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;

    modport master (
        output ex_valid, ex_result, ex_z, ex_cy, ex_dest, ex_wr_reg, ex_wr_flags, mem_ack,
        input  ex_ready, mem_wr_req, mem_addr, mem_wdata
    );

    modport slave (
        input  ex_valid, ex_result, ex_z, ex_cy, ex_dest, ex_wr_reg, ex_wr_flags, mem_ack,
        output ex_ready, mem_wr_req, mem_addr, mem_wdata
    );
endinterface

// File: rtl/regfile_8085.sv
// 8085 register file: B,C,D,E,H,L,A stored; index 6 (M) is never written and reads as zero.
module regfile_8085
    import pipe8085_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NREG = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [2:0]    waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [2:0]    ra_sel_i,
    output logic [DW-1:0] ra_data_o,
    input  logic [2:0]    rb_sel_i,
    output logic [DW-1:0] rb_data_o,
    output logic [DW-1:0] acc_o,
    output logic [DW-1:0] h_o,
    output logic [DW-1:0] l_o
);

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != REG_M)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign ra_data_o = (ra_sel_i == REG_M) ? '0 : regs_q[ra_sel_i];
    assign rb_data_o = (rb_sel_i == REG_M) ? '0 : regs_q[rb_sel_i];
    assign acc_o     = regs_q[REG_A];
    assign h_o       = regs_q[REG_H];
    assign l_o       = regs_q[REG_L];

endmodule

// File: rtl/alu_writeback_stage.sv
// EX->WB pipeline register behind the 8085 ALU: retires to the register file, the PSW,
// or to memory at {H,L} through a req/ack port; read ports bypass the pending result.
module alu_writeback_stage
    import pipe8085_pkg::*;
#(
    parameter int         DW        = 8,
    parameter int         NREG      = 8,
    parameter logic [7:0] FLAG_INIT = 8'h02
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    alu_writeback_stage_if.slave  wb,
    input  logic [2:0]            rd_a_sel_i,
    output logic [DW-1:0]         rd_a_data_o,
    input  logic [2:0]            rd_b_sel_i,
    output logic [DW-1:0]         rd_b_data_o,
    output logic [DW-1:0]         psw_o,
    output logic [DW-1:0]         acc_o,
    output logic                  wb_busy_o
);

    wb_state_t   state_q;
    wb_entry_t   entry_q;
    wb_entry_t   entry_d;
    logic [7:0]  psw_q;
    logic        mem_wr_req_q;
    logic [15:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;

    logic        capture;
    logic        cap_mem;
    logic        pending_wr;
    logic [7:0]  rf_a;
    logic [7:0]  rf_b;
    logic [7:0]  rf_h;
    logic [7:0]  rf_l;
    logic [7:0]  h_byp;
    logic [7:0]  l_byp;

    assign wb.ex_ready = (state_q != MEM_WAIT);
    assign capture     = wb.ex_valid & wb.ex_ready;
    assign cap_mem     = wb.ex_wr_reg & (wb.ex_dest == REG_M);
    assign pending_wr  = (state_q == FULL) & entry_q.wr_reg & (entry_q.dest != REG_M);

    assign entry_d = '{result:   wb.ex_result,
                       z:        wb.ex_z,
                       cy:       wb.ex_cy,
                       dest:     wb.ex_dest,
                       wr_reg:   wb.ex_wr_reg,
                       wr_flags: wb.ex_wr_flags};

    regfile_8085 #(.DW(DW), .NREG(NREG)) u_regfile (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (pending_wr),
        .waddr_i   (entry_q.dest),
        .wdata_i   (entry_q.result),
        .ra_sel_i  (rd_a_sel_i),
        .ra_data_o (rf_a),
        .rb_sel_i  (rd_b_sel_i),
        .rb_data_o (rf_b),
        .acc_o     (acc_o),
        .h_o       (rf_h),
        .l_o       (rf_l)
    );

    // The entry in FULL commits at the coming edge, so anything sampled now must see it.
    always_comb begin
        rd_a_data_o = rf_a;
        rd_b_data_o = rf_b;
        h_byp       = rf_h;
        l_byp       = rf_l;
        if (pending_wr && (entry_q.dest == rd_a_sel_i)) rd_a_data_o = entry_q.result;
        if (pending_wr && (entry_q.dest == rd_b_sel_i)) rd_b_data_o = entry_q.result;
        if (pending_wr && (entry_q.dest == REG_H))      h_byp       = entry_q.result;
        if (pending_wr && (entry_q.dest == REG_L))      l_byp       = entry_q.result;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= EMPTY;
            entry_q      <= '0;
            psw_q        <= FLAG_INIT;
            mem_wr_req_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                EMPTY, FULL: begin
                    if ((state_q == FULL) && entry_q.wr_flags) begin
                        psw_q <= make_psw(entry_q.result, entry_q.z, entry_q.cy);
                    end
                    if (capture) begin
                        entry_q <= entry_d;
                        if (cap_mem) begin
                            state_q      <= MEM_WAIT;
                            mem_wr_req_q <= 1'b1;
                            mem_addr_q   <= {h_byp, l_byp};
                            mem_wdata_q  <= wb.ex_result;
                        end else begin
                            state_q <= FULL;
                        end
                    end else begin
                        state_q <= EMPTY;
                    end
                end
                MEM_WAIT: begin
                    if (wb.mem_ack) begin
                        if (entry_q.wr_flags) begin
                            psw_q <= make_psw(entry_q.result, entry_q.z, entry_q.cy);
                        end
                        mem_wr_req_q <= 1'b0;
                        state_q      <= EMPTY;
                    end
                end
                default: begin
                    state_q      <= EMPTY;
                    mem_wr_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign wb.mem_wr_req = mem_wr_req_q;
    assign wb.mem_addr   = mem_addr_q;
    assign wb.mem_wdata  = mem_wdata_q;
    assign psw_o         = psw_q;
    assign wb_busy_o     = (state_q != EMPTY);

endmodule
